// File: rtl/pkg_6409.sv
// Shared definitions for the HI-6409 serial encode/decode paths.
// Word and counter widths, and the frame state encoding used on both sides.
package pkg_6409;

  localparam int unsigned WORD_W       = 16;
  localparam int unsigned COUNTER_W    = 18;
  localparam int unsigned BIT_IDX_W    = $clog2(WORD_W);
  localparam int unsigned MIN_HALF_DIV = 4;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } state_e;

endpackage

// File: rtl/tx_bit_timer_6409.sv
// Bit-period timer for the 6409 transmitter: counts 0..2*HALF_DIV-1 while running
// and flags the sclk fall point and the end of each bit period.
module tx_bit_timer_6409 #(
  parameter int unsigned HALF_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic run_i,
  input  logic clear_i,
  output logic rise_pulse_o,
  output logic fall_pulse_o,
  output logic bit_end_o
);

  localparam int unsigned CntW = $clog2(2 * HALF_DIV);
  localparam logic [CntW-1:0] FallCnt = CntW'(HALF_DIV - 1);
  localparam logic [CntW-1:0] EndCnt  = CntW'(2 * HALF_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (run_i) begin
      cnt_d = (cnt_q == EndCnt) ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Pulses are one cycle early: sclk/sdi are registered, so the edge lands next cycle.
  // The end of one bit period is also the rise of the next, hence rise == bit_end.
  assign fall_pulse_o = run_i && (cnt_q == FallCnt);
  assign bit_end_o    = run_i && (cnt_q == EndCnt);
  assign rise_pulse_o = bit_end_o;

endmodule

// File: rtl/encode_6409.sv
// HI-6409 serial transmitter: accepts a 16-bit word on valid/ready and shifts it out
// MSB-first with a self-generated sclk and a frame-enable (sden), then holds a gap.
module encode_6409 import pkg_6409::*; #(
  parameter int unsigned HALF_DIV   = 4,
  parameter int unsigned GAP_CYCLES = 8
) (
  input  logic                 clock_system,
  input  logic                 rstn,
  input  logic                 tx_en,
  input  logic [WORD_W-1:0]    data_in,
  input  logic                 data_valid,
  output logic                 data_ready,
  output logic                 sclk,
  output logic                 sdi,
  output logic                 sden,
  output logic                 tx_done,
  output logic [COUNTER_W-1:0] word_counter
);

  localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  state_e                 state_q, state_d;
  logic [WORD_W-1:0]      shreg_q, shreg_d;
  logic [BIT_IDX_W-1:0]   idx_q, idx_d;
  logic [GapW-1:0]        gap_q, gap_d;
  logic [COUNTER_W-1:0]   word_cnt_q, word_cnt_d;
  logic                   data_ready_q, data_ready_d;
  logic                   sclk_q, sclk_d;
  logic                   sdi_q, sdi_d;
  logic                   sden_q, sden_d;
  logic                   tx_done_q, tx_done_d;

  logic accept;
  logic last_bit;
  logic gap_last;
  logic rise_pulse, fall_pulse, bit_end;

  tx_bit_timer_6409 #(
    .HALF_DIV (HALF_DIV)
  ) u_bit_timer (
    .clk_i        (clock_system),
    .rst_ni       (rstn),
    .run_i        (state_q == SHIFT),
    .clear_i      ((state_q != SHIFT) || !tx_en),
    .rise_pulse_o (rise_pulse),
    .fall_pulse_o (fall_pulse),
    .bit_end_o    (bit_end)
  );

  assign accept   = (state_q == IDLE) && data_valid && data_ready_q && tx_en;
  assign last_bit = bit_end && (idx_q == '0);
  assign gap_last = (gap_q == GapW'(GAP_CYCLES - 1));

  // State register
  always_ff @(posedge clock_system or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; dropping tx_en aborts from anywhere
  always_comb begin
    state_d = state_q;
    if (!tx_en) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (accept)   state_d = SHIFT;
        SHIFT:   if (last_bit) state_d = GAP;
        GAP:     if (gap_last) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Next values of the registered outputs and datapath
  always_comb begin
    shreg_d      = shreg_q;
    idx_d        = idx_q;
    gap_d        = gap_q;
    sclk_d       = sclk_q;
    sdi_d        = sdi_q;
    sden_d       = sden_q;
    tx_done_d    = 1'b0;
    data_ready_d = (state_d == IDLE) && tx_en;
    word_cnt_d   = tx_done_q ? word_cnt_q + COUNTER_W'(1) : word_cnt_q;

    if (!tx_en) begin
      sclk_d = 1'b0;
      sdi_d  = 1'b0;
      sden_d = 1'b0;
      gap_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            shreg_d = data_in;
            sdi_d   = data_in[WORD_W-1];
            sclk_d  = 1'b1;
            sden_d  = 1'b1;
            idx_d   = BIT_IDX_W'(WORD_W - 1);
          end
        end
        SHIFT: begin
          if (fall_pulse) sclk_d = 1'b0;
          if (last_bit) begin
            sclk_d    = 1'b0;
            sdi_d     = 1'b0;
            sden_d    = 1'b0;
            gap_d     = '0;
            tx_done_d = (GAP_CYCLES == 1);
          end else if (rise_pulse) begin
            shreg_d = {shreg_q[WORD_W-2:0], 1'b0};
            sdi_d   = shreg_q[WORD_W-2];
            sclk_d  = 1'b1;
            idx_d   = idx_q - BIT_IDX_W'(1);
          end
        end
        GAP: begin
          gap_d = gap_q + GapW'(1);
          // tx_done must be registered high in the final gap cycle
          tx_done_d = (GAP_CYCLES > 1) && (gap_q == GapW'(GAP_CYCLES - 2));
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock_system or negedge rstn) begin
    if (!rstn) begin
      shreg_q      <= '0;
      idx_q        <= '0;
      gap_q        <= '0;
      word_cnt_q   <= '0;
      data_ready_q <= 1'b0;
      sclk_q       <= 1'b0;
      sdi_q        <= 1'b0;
      sden_q       <= 1'b0;
      tx_done_q    <= 1'b0;
    end else begin
      shreg_q      <= shreg_d;
      idx_q        <= idx_d;
      gap_q        <= gap_d;
      word_cnt_q   <= word_cnt_d;
      data_ready_q <= data_ready_d;
      sclk_q       <= sclk_d;
      sdi_q        <= sdi_d;
      sden_q       <= sden_d;
      tx_done_q    <= tx_done_d;
    end
  end

  assign data_ready   = data_ready_q;
  assign sclk         = sclk_q;
  assign sdi          = sdi_q;
  assign sden         = sden_q;
  assign tx_done      = tx_done_q;
  assign word_counter = word_cnt_q;

endmodule
